// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract split into SLICE-bit carry-lookahead stages with valid/ready handshake and status flags
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int N = WIDTH / SLICE;

    logic [WIDTH-1:0] a_q [N];
    logic [WIDTH-1:0] b_q [N];
    logic [WIDTH-1:0] s_q [N];
    logic [WIDTH-1:0] a_d [N];
    logic [WIDTH-1:0] b_d [N];
    logic [WIDTH-1:0] s_p [N];
    logic [WIDTH-1:0] s_d [N];
    logic [N-1:0]     c_q, c_p, c_d, v_q, v_d;
    logic             ov_q, z_q, n_q, ov_d, adv;
    logic [SLICE:0]   r;

    function automatic logic [SLICE:0] cla(input logic [SLICE-1:0] x, input logic [SLICE-1:0] y, input logic ci);
        logic [SLICE-1:0] g, p;
        logic [SLICE:0]   c;
        logic             pp, t;
        g = x & y;
        p = x ^ y;
        c = '0;
        c[0] = ci;
        for (int i = 0; i < SLICE; i++) begin
            pp = 1'b1;
            t = 1'b0;
            for (int j = i; j >= 0; j--) begin
                t = t | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = t | (pp & ci);
        end
        return {c[SLICE], p ^ c[SLICE-1:0]};
    endfunction

    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign out_valid = v_q[N-1];
    assign sum       = s_q[N-1];
    assign c_out     = c_q[N-1];
    assign overflow  = ov_q;
    assign zero      = z_q;
    assign negative  = n_q;

    // stage k takes the previous stage's skewed operands and carry, fills in its own sum slice
    always_comb begin
        a_d[0] = a;
        b_d[0] = sub ? ~b : b;
        s_p[0] = '0;
        c_p[0] = sub | c_in;
        v_d[0] = in_valid;
        for (int k = 1; k < N; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            s_p[k] = s_q[k-1];
            c_p[k] = c_q[k-1];
            v_d[k] = v_q[k-1];
        end
        r   = '0;
        c_d = '0;
        for (int k = 0; k < N; k++) begin
            r = cla(a_d[k][k*SLICE +: SLICE], b_d[k][k*SLICE +: SLICE], c_p[k]);
            s_d[k] = s_p[k];
            s_d[k][k*SLICE +: SLICE] = r[SLICE-1:0];
            c_d[k] = r[SLICE];
        end
        ov_d = (a_d[N-1][WIDTH-1] == b_d[N-1][WIDTH-1]) & (s_d[N-1][WIDTH-1] != a_d[N-1][WIDTH-1]);
    end

    // whole pipeline shifts together on advance and freezes on a stalled output
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '{default: '0};
            b_q  <= '{default: '0};
            s_q  <= '{default: '0};
            c_q  <= '0;
            v_q  <= '0;
            ov_q <= 1'b0;
            z_q  <= 1'b0;
            n_q  <= 1'b0;
        end else if (adv) begin
            a_q  <= a_d;
            b_q  <= b_d;
            s_q  <= s_d;
            c_q  <= c_d;
            v_q  <= v_d;
            ov_q <= ov_d;
            z_q  <= ~|s_d[N-1];
            n_q  <= s_d[N-1][WIDTH-1];
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed vectors, throughput, random stall/reset stream and a 64/8 latency check
module tb_pipelined_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv, ir, ovl, ordy, cin, sb, co, ovf, z, n;
    logic [31:0] a, b, s;
    logic        iv6, ir6, ovl6, ordy6, cin6, sb6, co6, ovf6, z6, n6;
    logic [63:0] a6, b6, s6;

    pipelined_addsub #(.WIDTH(32), .SLICE(16)) d32 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .c_in(cin), .sub(sb),
        .out_valid(ovl), .out_ready(ordy), .sum(s), .c_out(co), .overflow(ovf), .zero(z), .negative(n)
    );

    pipelined_addsub #(.WIDTH(64), .SLICE(8)) d64 (
        .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir6), .a(a6), .b(b6), .c_in(cin6), .sub(sb6),
        .out_valid(ovl6), .out_ready(ordy6), .sum(s6), .c_out(co6), .overflow(ovf6), .zero(z6), .negative(n6)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        ci, sb;
        logic [31:0] s;
        logic        c, v, z, n;
    } vec_t;

    vec_t tv[10];

    // independent reference: plain 33-bit arithmetic, flags from definitions
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sbt);
        logic [31:0] be;
        logic [32:0] rr;
        be = sbt ? ~y : y;
        rr = {1'b0, x} + {1'b0, be} + {32'd0, sbt | ci};
        return {rr[31:0], rr[32], (x[31] == be[31]) && (rr[31] != x[31]), rr[31:0] == 32'd0, rr[31]};
    endfunction

    task automatic run_vec(input int i);
        int lat;
        @(negedge clk);
        a = tv[i].a; b = tv[i].b; cin = tv[i].ci; sb = tv[i].sb; iv = 1'b1; ordy = 1'b1;
        #1 chk($sformatf("in_ready_%0d", i), ir, 1);
        @(posedge clk);
        #1 iv = 1'b0;
        lat = 1;
        while (!ovl && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        chk($sformatf("latency32_%0d", i), lat, 2);
        chk($sformatf("vec_%0d", i), {s, co, ovf, z, n}, {tv[i].s, tv[i].c, tv[i].v, tv[i].z, tv[i].n});
    endtask

    initial begin
        logic [35:0] q[$];
        logic [35:0] ex[4];
        logic [35:0] cur, prev, e;
        logic [67:0] e6[2];
        logic [63:0] va[2], vb[2];
        logic        stalled, after_rst;
        int          sent, acc_post, got_post, cyc, lat;

        iv = 0; ordy = 1; a = 0; b = 0; cin = 0; sb = 0;
        iv6 = 0; ordy6 = 1; a6 = 0; b6 = 0; cin6 = 0; sb6 = 0;
        tv[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[2] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[5] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[6] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[8] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[9] = '{32'h12345678, 32'h0000FFFF, 1'b0, 1'b0, 32'h12355677, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset32", {ovl, s, co, ovf, z, n, ir}, {1'b0, 32'd0, 4'd0, 1'b1});
        chk("reset64", {ovl6, s6, co6, ovf6, z6, n6, ir6}, {1'b0, 64'd0, 4'd0, 1'b1});
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i);

        // back-to-back stream with the consumer always ready: no bubbles
        for (int i = 0; i < 4; i++) ex[i] = model(32'h0000FFFF + i, 32'h00010001 * i, i[0], i[1]);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ordy = 1'b1;
            iv = (i < 4);
            a = 32'h0000FFFF + i; b = 32'h00010001 * i; cin = i[0]; sb = i[1];
            #1;
            if (i == 1) chk("tput_first_empty", ovl, 0);
            if (i >= 2) begin
                chk($sformatf("tput_valid_%0d", i - 2), ovl, 1);
                chk($sformatf("tput_result_%0d", i - 2), {s, co, ovf, z, n}, ex[i-2]);
            end
        end
        @(negedge clk);
        iv = 1'b0;

        // random stream with random back-pressure and a one-cycle reset mid-stream
        sent = 0; acc_post = 0; got_post = 0; stalled = 0; after_rst = 0; prev = '0;
        for (cyc = 0; cyc < 400 && !(cyc > 6 && sent >= 10 && q.size() == 0); cyc++) begin
            @(negedge clk);
            rst  = (cyc == 5);
            ordy = 1'($urandom_range(0, 1));
            iv   = !rst && sent < 10 && $urandom_range(0, 3) != 0;
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
            #1;
            cur = {s, co, ovf, z, n};
            if (after_rst) chk("post_rst_out_valid", ovl, 0);
            if (stalled) begin
                chk("stall_valid", ovl, 1);
                chk("stall_hold", cur, prev);
            end
            if (!rst && ovl && ordy) begin
                if (q.size() == 0) chk("stream_unexpected", 1, 0);
                else begin
                    e = q.pop_front();
                    chk($sformatf("stream_result_c%0d", cyc), cur, e);
                    if (cyc > 5) got_post++;
                end
            end
            if (!rst && iv && ir) begin
                q.push_back(model(a, b, cin, sb));
                sent++;
                if (cyc > 5) acc_post++;
            end
            if (rst) q.delete();
            stalled   = !rst && ovl && !ordy;
            prev      = cur;
            after_rst = rst;
        end
        @(negedge clk);
        rst = 1'b0; iv = 1'b0; ordy = 1'b1;
        chk("stream_drained", q.size(), 0);
        chk("stream_post_count", got_post, acc_post);

        // 64-bit, 8-bit slices: eight registered stages
        va[0] = 64'h00000000FFFFFFFF; vb[0] = 64'd1;
        e6[0] = {64'h0000000100000000, 4'b0000};
        va[1] = 64'hFFFFFFFFFFFFFFFF; vb[1] = 64'd1;
        e6[1] = {64'h0000000000000000, 4'b1010};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a6 = va[i]; b6 = vb[i]; cin6 = 1'b0; sb6 = 1'b0; iv6 = 1'b1; ordy6 = 1'b1;
            @(posedge clk);
            #1 iv6 = 1'b0;
            lat = 1;
            while (!ovl6 && lat < 20) begin
                @(posedge clk);
                #1 lat++;
            end
            chk($sformatf("latency64_%0d", i), lat, 8);
            chk($sformatf("vec64_%0d", i), {s6, co6, ovf6, z6, n6}, e6[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the 32-bit two-slice carry-lookahead adder.
- Splits a WIDTH-bit add/subtract into SLICE-bit carry-lookahead slices, one slice per pipeline stage, with the inter-slice carry registered.
- Adds a valid/ready handshake, a subtract mode and status flags.
- Sits as the adder/ALU arithmetic unit in the datapath and sustains one operation per cycle.

Parameters:
- WIDTH, 32: operand and sum width in bits. Must be a multiple of SLICE.
- SLICE, 16: bits per carry-lookahead slice and pipeline stage. NUM_STAGES = WIDTH/SLICE (1..8).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  the operand set on a, b, c_in, sub is valid.
- in_ready  output  1  the block accepts the operand set this cycle.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- c_in  input  1  carry-in. Used only when sub=0.
- sub  input  1  0: a+b+c_in. 1: a-b, computed as a+~b+1.
- out_valid  output  1  sum and flags are valid.
- out_ready  input  1  the consumer accepts the result this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  carry out of the MSB. For sub, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.
- negative  output  1  sum[WIDTH-1].

Behaviour:
- Reset (rst=1 at a clock edge):
  - All stage valid bits cleared.
  - sum, c_out, overflow, zero and negative all 0.
  - out_valid=0.
  - Reset mid-operation discards every in-flight operation; no partial result is ever presented.
- Advance condition: adv = out_ready | ~out_valid.
  - in_ready = adv, combinational. No dependence on in_valid.
  - Global stall: when adv=0, every stage register holds, including the valid bits.
- Stage k (0..NUM_STAGES-1):
  - Adds slice k of a and beff (beff = sub ? ~b : b) plus the registered carry from stage k-1.
  - Stage 0 carry-in = sub ? 1 : c_in.
  - Each slice is carry-lookahead internally, not ripple.
- Operand skew: the upper slices of a and beff travel with the operation through delay registers until their stage; lower sum slices are carried forward.
- Valid bits propagate with the data.
  - A bubble (in_valid=0 at an advancing edge) enters as valid=0. The data registers of a bubble may update (don't care).
- Latency: a result is presented exactly NUM_STAGES cycles after acceptance (in_valid & in_ready) with no stalls, plus one cycle per stalled cycle.
- Throughput: one operation per cycle while out_ready=1.
- Ordering: results emerge strictly in acceptance order. Nothing is dropped or duplicated under any stall pattern.
- Output hold: sum and flags are registered. While out_valid=1 and out_ready=0 they stay stable.
- Flags are computed from the final stage's full sum and are valid only when out_valid=1:
  - c_out: carry out of bit WIDTH-1.
  - overflow = (a[MSB] == beff[MSB]) & (sum[MSB] != a[MSB]).
  - zero = ~|sum.
  - negative = sum[MSB].
- Simultaneous accept and drain: when out_valid=1, out_ready=1 and in_valid=1, the pipeline shifts. A full pipeline sustains one operation per cycle with no bubble.
- NUM_STAGES=1 degenerates to a single registered adder with latency 1.
- Inputs presented while in_ready=0 are ignored.

Test Plan:
- WIDTH=32, SLICE=16: a=32'h0000FFFF, b=32'h00000001, c_in=0, sub=0 -> after 2 cycles sum=32'h00010000 (crosses the slice carry), c_out=0, overflow=0, zero=0.
- sub=1, a=5, b=5 -> sum=0, zero=1, c_out=1, overflow=0.
- sub=1, a=0, b=1 -> sum=32'hFFFFFFFF, negative=1, c_out=0 (borrow).
- a=32'h7FFFFFFF, b=1, sub=0 -> sum=32'h80000000, overflow=1, negative=1.
- a=32'hFFFFFFFF, b=1, c_in=1 -> sum=1, c_out=1, overflow=0.
- Back-to-back stream of 10 random operations; out_ready toggles randomly; rst asserted for one cycle mid-stream:
  - out_valid=0 the cycle after rst.
  - The pre-reset results that have been consumed match a reference model in order, with no loss or duplication; operations still in flight at rst are discarded.
  - Post-reset operations follow correctly with no stale data.
  - Output stays stable while stalled.
- WIDTH=64, SLICE=8 instance: latency exactly 8 cycles.
- a=64'h00000000FFFFFFFF, b=1 -> sum=64'h0000000100000000 (carry ripples through four registered slices).
